// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the processor top:
// loader FSM states, stream byte width and instruction/address widths.
package imem_loader_pkg;

    localparam int LOADER_BYTE_W = 8;
    localparam int INSTR_W       = 32;
    localparam int IMEM_ADDR_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-SRAM write port of the loader.
// master: the loader (consumes the stream, drives the SRAM write port).
// slave:  the environment (byte source and instruction memory).
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int W = INSTR_W,
    parameter int N = IMEM_ADDR_W
);
    logic [LOADER_BYTE_W-1:0] byte_i;
    logic                     byte_valid;
    logic                     byte_ready;
    logic [N-1:0]             mem_addr;
    logic [W-1:0]             mem_data;
    logic                     mem_cs;
    logic                     mem_we;

    modport master (
        input  byte_i, byte_valid,
        output byte_ready, mem_addr, mem_data, mem_cs, mem_we
    );

    modport slave (
        output byte_i, byte_valid,
        input  byte_ready, mem_addr, mem_data, mem_cs, mem_we
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles stream bytes (MSB first) into instruction words and keeps the
// running XOR of every data byte. word_full flags that the byte now being
// accepted is the last one of the current word.
module imem_loader_word_packer
    import imem_loader_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     accept,
    input  logic [LOADER_BYTE_W-1:0] byte_i,
    output logic [W-1:0]             word_nxt,
    output logic [LOADER_BYTE_W-1:0] acc,
    output logic                     word_full
);
    localparam int BPW   = W / LOADER_BYTE_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPW - 1);

    logic [W-1:0]             word_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [LOADER_BYTE_W-1:0] acc_r;

    // Word value after shifting in the current byte; the top commits it on the last byte.
    always_comb begin
        word_nxt = (word_r << LOADER_BYTE_W) | W'(byte_i);
    end

    assign acc       = acc_r;
    assign word_full = (cnt_r == CNT_LAST);

    // Shift register, byte counter and checksum accumulator.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_r <= '0;
            cnt_r  <= '0;
            acc_r  <= '0;
        end else if (accept) begin
            word_r <= word_nxt;
            acc_r  <= acc_r ^ byte_i;
            cnt_r  <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: header, data words, XOR checksum. Writes each
// assembled word into the instruction SRAM and keeps the CPU in reset until
// a complete image has been loaded with a matching checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int W = INSTR_W,
    parameter int N = IMEM_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);
    loader_state_e            state_r;
    loader_state_e            nxt_s;
    logic [N-1:0]             addr_r;
    logic [N-1:0]             last_r;
    logic [N-1:0]             mem_addr_r;
    logic [W-1:0]             mem_data_r;
    logic [W-1:0]             word_nxt_s;
    logic [LOADER_BYTE_W-1:0] acc_s;
    logic                     word_full_s;
    logic                     accept_s;
    logic                     data_accept_s;
    logic                     start_go_s;
    logic                     byte_ready_r;
    logic                     mem_cs_r;
    logic                     mem_we_r;
    logic                     cpu_reset_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     err_r;

    assign accept_s      = bus.byte_valid && byte_ready_r;
    assign data_accept_s = accept_s && (state_r == ST_DATA);
    assign start_go_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));

    imem_loader_word_packer #(.W(W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_go_s),
        .accept    (data_accept_s),
        .byte_i    (bus.byte_i),
        .word_nxt  (word_nxt_s),
        .acc       (acc_s),
        .word_full (word_full_s)
    );

    // Next-state decision for the load sequence.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) nxt_s = ST_HDR;
                else       nxt_s = state_r;
            end
            ST_HDR: begin
                if (accept_s) nxt_s = ST_DATA;
                else          nxt_s = ST_HDR;
            end
            ST_DATA: begin
                if (accept_s && word_full_s) nxt_s = ST_WRITE;
                else                         nxt_s = ST_DATA;
            end
            ST_WRITE: begin
                if (addr_r == last_r) nxt_s = ST_CHK;
                else                  nxt_s = ST_DATA;
            end
            ST_CHK: begin
                if (accept_s) nxt_s = (bus.byte_i == acc_s) ? ST_DONE : ST_ERR;
                else          nxt_s = ST_CHK;
            end
            default: nxt_s = ST_IDLE;
        endcase
    end

    // State, word address, committed write port and outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            last_r       <= '0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            byte_ready_r <= 1'b0;
            mem_cs_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            cpu_reset_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r <= nxt_s;
            if (start_go_s) begin
                addr_r <= '0;
            end else if ((state_r == ST_WRITE) && (addr_r != last_r)) begin
                addr_r <= addr_r + N'(1);
            end
            if ((state_r == ST_HDR) && accept_s) begin
                last_r <= N'(bus.byte_i);
            end
            if ((state_r == ST_DATA) && (nxt_s == ST_WRITE)) begin
                mem_addr_r <= addr_r;
                mem_data_r <= word_nxt_s;
            end
            byte_ready_r <= (nxt_s == ST_HDR) || (nxt_s == ST_DATA) || (nxt_s == ST_CHK);
            busy_r       <= (nxt_s == ST_HDR) || (nxt_s == ST_DATA) || (nxt_s == ST_CHK) || (nxt_s == ST_WRITE);
            mem_cs_r     <= (nxt_s == ST_WRITE);
            mem_we_r     <= (nxt_s == ST_WRITE);
            cpu_reset_r  <= (nxt_s != ST_DONE);
            done_r       <= (nxt_s == ST_DONE);
            err_r        <= (nxt_s == ST_ERR);
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_data   = mem_data_r;
    assign bus.mem_cs     = mem_cs_r;
    assign bus.mem_we     = mem_we_r;
    assign cpu_reset      = cpu_reset_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader. The reference model turns an
// image (header, words, checksum) into the list of expected SRAM writes and
// the expected final status; a monitor checks every mem_we pulse.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_reset, busy, done, err;

    imem_loader_if #(.W(32), .N(8)) bus ();

    imem_loader #(.W(32), .N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[256];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (!reset && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we_addr", {56'd0, bus.mem_addr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {56'd0, bus.mem_addr}, {56'd0, e.a});
                chk("wr_data", {32'd0, bus.mem_data}, {32'd0, e.d});
                chk("wr_cs", {63'd0, bus.mem_cs}, 64'd1);
                chk("wr_ready_low", {63'd0, bus.byte_ready}, 64'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int n;
        if ($urandom_range(99) < gap_pct) begin
            bus.byte_valid = 1'b0;
            bus.byte_i     = 8'($urandom);
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end
        bus.byte_i     = b;
        bus.byte_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.byte_ready) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL ready_timeout actual=0 expected=1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, {63'd0, e_done});
        chk({tag, "_err"}, {63'd0, err}, {63'd0, e_err});
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, {63'd0, ~e_done});
        chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Model: image img[0..h] with checksum (correct unless corrupted by ck_flip).
    task automatic run_load(input string tag, input int h, input logic [7:0] ck_flip,
                            input int gap_pct, input logic busy_start);
        logic [7:0]  x;
        logic [7:0]  ck;
        logic [31:0] w;
        x = 8'd0;
        for (int i = 0; i <= h; i++) begin
            wr_t e;
            e.a = 8'(i);
            e.d = img[i];
            exp_q.push_back(e);
            w = img[i];
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        ck = x ^ ck_flip;
        // header presented together with start: only start may act this cycle
        bus.byte_i     = 8'(h);
        bus.byte_valid = 1'b1;
        pulse_start();
        chk({tag, "_cpu_reset_loading"}, {63'd0, cpu_reset}, 64'd1);
        send_byte(8'(h), gap_pct);
        for (int i = 0; i <= h; i++) begin
            if (busy_start && i == 10) begin
                bus.byte_valid = 1'b0;
                pulse_start();
            end
            w = img[i];
            for (int b = 3; b >= 0; b--) begin
                send_byte(w[b*8 +: 8], gap_pct);
            end
        end
        send_byte(ck, gap_pct);
        bus.byte_valid = 1'b0;
        check_status(tag, ck_flip == 8'd0, ck_flip != 8'd0);
    endtask

    initial begin
        bus.byte_i     = 8'd0;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
        chk("rst_mem_addr", {56'd0, bus.mem_addr}, 64'd0);
        chk("rst_mem_data", {32'd0, bus.mem_data}, 64'd0);
        chk("rst_mem_cs_we", {62'd0, bus.mem_cs, bus.mem_we}, 64'd0);
        chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("rst_status", {61'd0, busy, done, err}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single word
        img[0] = 32'h12345678;
        run_load("single", 0, 8'h00, 0, 1'b0);

        // three words, checksum 00
        img[0] = 32'h00000001;
        img[1] = 32'h00000002;
        img[2] = 32'h00000003;
        run_load("three", 2, 8'h00, 0, 1'b0);

        // bad checksum (FF instead of 08)
        img[0] = 32'h12345678;
        run_load("badck", 0, 8'hF7, 0, 1'b0);

        // reset mid-load after two data bytes
        bus.byte_i     = 8'h01;
        bus.byte_valid = 1'b1;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        bus.byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
        chk("midrst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("midrst_status", {61'd0, busy, done, err}, 64'd0);
        repeat (8) @(negedge clk);
        chk("midrst_idle_ready", {63'd0, bus.byte_ready}, 64'd0);
        img[0] = 32'hCAFEF00D;
        run_load("after_rst", 0, 8'h00, 0, 1'b0);

        // randomised images with gaps and occasional bad checksums
        for (int t = 0; t < 6; t++) begin
            int h;
            logic [7:0] flip;
            h = $urandom_range(7, 0);
            for (int i = 0; i <= h; i++) img[i] = $urandom;
            flip = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_load("rand", h, flip, 40, 1'b0);
        end

        // full image, data = address, with an ignored start while busy
        for (int i = 0; i < 256; i++) img[i] = 32'(i);
        run_load("full", 255, 8'h00, 10, 1'b1);
        chk("full_last_addr", {56'd0, bus.mem_addr}, 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
